// File: rtl/rsa_modexp_unit.sv
// RSA modular exponentiation: right-to-left square-and-multiply over a bit-serial modmul.
// RSA_CONST_TIME_EN: run MUL for every exponent bit, commit only when the bit is set.
module rsa_modexp_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_rsa,
    input  logic             rst_rsa,
    input  logic [WIDTH-1:0] plain_text,
    input  logic [WIDTH-1:0] exp_e,
    input  logic [WIDTH-1:0] mod_n,
    output logic [WIDTH-1:0] cipher_text,
    output logic             eoc_rsa_unit,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        SQR,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] e_q, n_q, res_q, base_q, acc_q;
    logic [CW-1:0]    cnt_q, bitcnt_q, bitcnt_inc;
    logic             err_res_q;

    logic [WIDTH-1:0] mm_a, mm_b, mm_out;
    logic [WIDTH:0]   n_ext, dbl, dbl_r, add;
    logic             last_step, op_err, commit_res;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (!rst_rsa) begin
            state_q <= IDLE;
        end else if (en_rsa) begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (op_err) begin
                    state_d = DONE;
                end else begin
`ifdef RSA_CONST_TIME_EN
                    state_d = MUL;
`else
                    state_d = exp_e[0] ? MUL : SQR;
`endif
                end
            end
            MUL: begin
                if (last_step) begin
                    state_d = SQR;
                end
            end
            SQR: begin
                if (last_step) begin
                    if (bitcnt_q == CMAX) begin
                        state_d = DONE;
                    end else begin
`ifdef RSA_CONST_TIME_EN
                        state_d = MUL;
`else
                        state_d = e_q[bitcnt_inc] ? MUL : SQR;
`endif
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // datapath decode: operand select and one modmul reduction step
    always_comb begin
        n_ext      = {1'b0, n_q};
        mm_a       = (state_q == MUL) ? res_q : base_q;
        mm_b       = base_q;
        dbl        = {acc_q, 1'b0};
        dbl_r      = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
        add        = dbl_r + (mm_b[CMAX - cnt_q] ? {1'b0, mm_a} : '0);
        mm_out     = WIDTH'((add >= n_ext) ? (add - n_ext) : add);
        last_step  = (cnt_q == CMAX);
        bitcnt_inc = bitcnt_q + CW'(1);
        op_err     = (mod_n < WIDTH'(2)) || (plain_text >= mod_n);
`ifdef RSA_CONST_TIME_EN
        commit_res = e_q[bitcnt_q];
`else
        commit_res = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q          <= '0;
            n_q          <= '0;
            res_q        <= '0;
            base_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            bitcnt_q     <= '0;
            err_res_q    <= 1'b0;
            cipher_text  <= '0;
            eoc_rsa_unit <= 1'b0;
            err          <= 1'b0;
        end else if (!rst_rsa) begin
            // result and its error flag survive the soft clear
            eoc_rsa_unit <= 1'b0;
            err          <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
        end else if (en_rsa) begin
            unique case (state_q)
                LOAD: begin
                    e_q       <= exp_e;
                    n_q       <= mod_n;
                    res_q     <= WIDTH'(1);
                    base_q    <= plain_text;
                    bitcnt_q  <= '0;
                    cnt_q     <= '0;
                    acc_q     <= '0;
                    err_res_q <= op_err;
                    if (op_err) begin
                        err         <= 1'b1;
                        cipher_text <= '0;
                    end
                end
                MUL, SQR: begin
                    if (last_step) begin
                        cnt_q <= '0;
                        acc_q <= '0;
                        if (state_q == MUL) begin
                            if (commit_res) begin
                                res_q <= mm_out;
                            end
                        end else begin
                            base_q <= mm_out;
                            if (bitcnt_q != CMAX) begin
                                bitcnt_q <= bitcnt_inc;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        acc_q <= mm_out;
                    end
                end
                DONE: begin
                    eoc_rsa_unit <= 1'b1;
                    err          <= err_res_q;
                    if (!err_res_q) begin
                        cipher_text <= res_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Directed bench for rsa_modexp_unit (WIDTH=8) with an expected-result queue.
// Latency model follows RSA_CONST_TIME_EN when the macro is defined.
module tb_rsa_modexp_unit;

    typedef struct {
        int ct;
        int er;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en_rsa, rst_rsa;
    logic [7:0] plain_text, exp_e, mod_n;
    logic [7:0] cipher_text;
    logic       eoc_rsa_unit, err;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    rsa_modexp_unit #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_rsa       (en_rsa),
        .rst_rsa      (rst_rsa),
        .plain_text   (plain_text),
        .exp_e        (exp_e),
        .mod_n        (mod_n),
        .cipher_text  (cipher_text),
        .eoc_rsa_unit (eoc_rsa_unit),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int m, input int e, input int n);
        exp_t r;
        int   acc, b;
        if (n < 2 || m >= n) begin
            r.ct  = 0;
            r.er  = 1;
            r.lat = 2;
            return r;
        end
        acc = 1;
        b   = m;
        for (int i = 0; i < 8; i++) begin
            if (((e >> i) & 1) == 1) acc = (acc * b) % n;
            b = (b * b) % n;
        end
        r.ct = acc;
        r.er = 0;
`ifdef RSA_CONST_TIME_EN
        r.lat = 2 + 2 * 8 * 8;
`else
        r.lat = 2 + 8 * (8 + $countones(e[7:0]));
`endif
        return r;
    endfunction

    // soft clear back to IDLE, then present operands; the next posedge is edge 0
    task automatic start(input int m, input int e, input int n);
        @(negedge clk);
        rst_rsa = 1'b0;
        en_rsa  = 1'b1;
        @(negedge clk);
        plain_text = 8'(m);
        exp_e      = 8'(e);
        mod_n      = 8'(n);
        rst_rsa    = 1'b1;
        q.push_back(model(m, e, n));
    endtask

    task automatic wait_eoc(input string tag, input int from);
        int   lat;
        exp_t x;
        lat = -1;
        for (int n = from; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (eoc_rsa_unit === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (q.size() == 0) begin
            chk({tag, "_queue"}, 0, 1);
            return;
        end
        x = q.pop_front();
        if (lat < 0) begin
            chk({tag, "_timeout"}, lat, x.lat);
            return;
        end
        chk({tag, "_ct"}, int'(cipher_text), x.ct);
        chk({tag, "_err"}, int'(err), x.er);
        chk({tag, "_lat"}, lat, x.lat);
    endtask

    initial begin
        rst        = 1'b1;
        en_rsa     = 1'b0;
        rst_rsa    = 1'b0;
        plain_text = '0;
        exp_e      = '0;
        mod_n      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ct", int'(cipher_text), 0);
        chk("rst_eoc", int'(eoc_rsa_unit), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;

        start(7, 7, 33);
        wait_eoc("m7e7", 0);
        start(28, 3, 33);
        wait_eoc("m28e3", 0);
        start(5, 0, 33);
        wait_eoc("e0", 0);
        start(40, 3, 33);
        wait_eoc("m_ge_n", 0);
        start(5, 3, 1);
        wait_eoc("n1", 0);
        start(0, 3, 0);
        wait_eoc("n0", 0);
        start(255, 255, 255);
        wait_eoc("m255", 0);
        start(254, 255, 255);
        wait_eoc("m254", 0);
        start(2, 170, 251);
        wait_eoc("m2e170", 0);

        // abort mid-run with the soft clear
        start(7, 7, 33);
        void'(q.pop_back());
        repeat (30) @(posedge clk);
        #1 rst_rsa = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_eoc", int'(eoc_rsa_unit), 0);
        chk("abort_err", int'(err), 0);
        start(28, 3, 33);
        wait_eoc("restart", 0);

        // freeze 10 cycles inside the first MUL
        start(7, 7, 33);
        q[0].lat = q[0].lat + 10;
        repeat (5) @(posedge clk);
        #1 en_rsa = 1'b0;
        repeat (10) @(posedge clk);
        #1 en_rsa = 1'b1;
        wait_eoc("freeze", 15);

        @(negedge clk);
        rst_rsa = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_eoc", int'(eoc_rsa_unit), 0);
        chk("clr_ct", int'(cipher_text), 28);
        chk("clr_err", int'(err), 0);

        // hard reset mid-run
        start(28, 3, 33);
        void'(q.pop_back());
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("hrst_ct", int'(cipher_text), 0);
        chk("hrst_eoc", int'(eoc_rsa_unit), 0);
        chk("hrst_err", int'(err), 0);
        rst = 1'b0;
        start(7, 7, 33);
        wait_eoc("post_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
